// File: rtl/wii_ext_i2c_target.sv
// I2C target emulating a Wii Classic Controller extension (init writes, pointer write, 6-byte report reads).
// SDA is sampled on SCL rise and changed only SDA_HOLD_CLKS clocks after a detected SCL fall.
module wii_ext_i2c_target #(
    parameter logic [6:0] DEV_ADDR      = 7'h52,
    parameter int         SYNC_STAGES   = 2,
    parameter int         SDA_HOLD_CLKS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [47:0] report,
    output logic        init_done,
    output logic        busy,
    output logic        rd_done
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_p, sda_p;
    logic scl_rise, scl_fall, start_c, stop_c, hold_evt;
    logic [7:0] hold_cnt;

    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  ptr, ptr_n;
    logic        sda_oe_n, rw, rw_n, first_byte, first_n;
    logic        f0_ok, f0_n, fb_ok, fb_n, rd_done_n, snap;
    logic [47:0] shadow;
    logic [7:0]  cur_byte;
    logic [2:0]  bit_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
            hold_cnt <= 8'd0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
            if (scl_fall)
                hold_cnt <= 8'(SDA_HOLD_CLKS);
            else if (hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;
    // Fires once, SDA_HOLD_CLKS clocks after the last SCL fall.
    assign hold_evt = (hold_cnt == 8'd1);

    always_comb begin
        cur_byte = 8'hFF;
        if (ptr <= 8'h05)
            cur_byte = shadow[{ptr[2:0], 3'b000} +: 8];
    end

    assign bit_idx = 3'd7 - bit_cnt[2:0];

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        sda_oe_n  = sda_oe;
        ptr_n     = ptr;
        rw_n      = rw;
        first_n   = first_byte;
        f0_n      = f0_ok;
        fb_n      = fb_ok;
        rd_done_n = 1'b0;
        snap      = 1'b0;
        if (start_c) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else if (stop_c) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ADDR, WR_BYTE: if (scl_rise) begin
                    shift_n   = {shift[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = 4'd0;
                        if (state == ADDR) begin
                            if (shift[6:0] == DEV_ADDR) begin
                                state_n = ADDR_ACK;
                                rw_n    = sda_s;
                                snap    = sda_s;
                                first_n = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end else begin
                            state_n = WR_ACK;
                            if (first_byte) begin
                                ptr_n   = shift_n;
                                first_n = 1'b0;
                            end else begin
                                ptr_n = ptr + 8'd1;
                                if (ptr == 8'hF0) f0_n = (shift_n == 8'h55);
                                if (ptr == 8'hFB) fb_n = (shift_n == 8'h00);
                            end
                        end
                    end
                end
                // sda_oe doubles as the phase flag: low = ACK not yet driven.
                ADDR_ACK, WR_ACK: if (hold_evt) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else if (state == WR_ACK || !rw) begin
                        sda_oe_n = 1'b0;
                        state_n  = WR_BYTE;
                    end else begin
                        sda_oe_n  = ~cur_byte[7];
                        bit_cnt_n = 4'd1;
                        state_n   = RD_BYTE;
                    end
                end
                RD_BYTE: if (hold_evt) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        state_n  = RD_ACK;
                    end else begin
                        sda_oe_n  = ~cur_byte[bit_idx];
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    ptr_n     = ptr + 8'd1;
                    bit_cnt_n = 4'd0;
                    if (sda_s) begin
                        rd_done_n = 1'b1;
                        state_n   = WAIT_STOP;
                    end else begin
                        state_n = RD_BYTE;
                    end
                end
                WAIT_STOP: sda_oe_n = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'd0;
            sda_oe     <= 1'b0;
            ptr        <= 8'd0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            f0_ok      <= 1'b0;
            fb_ok      <= 1'b0;
            init_done  <= 1'b0;
            rd_done    <= 1'b0;
            shadow     <= 48'd0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            sda_oe     <= sda_oe_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            first_byte <= first_n;
            f0_ok      <= f0_n;
            fb_ok      <= fb_n;
            init_done  <= init_done | (f0_ok & fb_ok);
            rd_done    <= rd_done_n;
            if (snap)
                shadow <= report;
        end
    end

    assign busy = (state != IDLE);

endmodule
